// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and width helpers for the data-memory arbiter
package dmem_arb_pkg;

  typedef enum logic {S_CPU, S_EXT} arb_state_t;

  localparam int D_WIDTH_DEF      = 32;
  localparam int MAX_BURST_DEF    = 8;
  localparam int STARVE_LIMIT_DEF = 4;

  // Counter width that holds 0..n-1, never narrower than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arb_sat_counter.sv
// rtl/arb_sat_counter.sv - saturating up-counter with clear priority, async reset
module arb_sat_counter #(
  parameter int W     = 3,
  parameter int LIMIT = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_sat = (r_cnt == LIM);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port DataMemory between the CPU memory stage and an EXT burst port
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int D_WIDTH      = D_WIDTH_DEF,
  parameter int MAX_BURST    = MAX_BURST_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cpu_req,
  input  logic               i_cpu_we,
  input  logic               i_cpu_adtp,
  input  logic [D_WIDTH-1:0] i_cpu_addr,
  input  logic [D_WIDTH-1:0] i_cpu_wdata,
  output logic [D_WIDTH-1:0] o_cpu_rdata,
  output logic               o_cpu_stall,
  input  logic               i_ext_valid,
  output logic               o_ext_ready,
  input  logic               i_ext_we,
  input  logic [D_WIDTH-1:0] i_ext_addr,
  input  logic [D_WIDTH-1:0] i_ext_wdata,
  input  logic               i_ext_last,
  output logic               o_ext_rvalid,
  output logic [D_WIDTH-1:0] o_ext_rdata,
  output logic               o_mem_we,
  output logic               o_mem_adtp,
  output logic [D_WIDTH-1:0] o_mem_a,
  output logic [D_WIDTH-1:0] o_mem_wd,
  input  logic [D_WIDTH-1:0] i_mem_rd
);

  localparam int BW = cnt_w(MAX_BURST);
  localparam int SW = cnt_w(STARVE_LIMIT + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  arb_state_t    r_state, w_state_nxt;
  logic [BW-1:0] r_beat_cnt, w_beat_nxt;
  logic [SW-1:0] w_starve_cnt;
  logic          w_starve_sat;
  logic          w_grant, w_xfer, w_mem_we;
  logic          w_starve_inc, w_starve_clr;

  // CPU keeps the memory until EXT is idle-granted or has waited STARVE_LIMIT cycles
  assign w_starve_inc = (r_state == S_CPU) & i_ext_valid & i_cpu_req;
  assign w_starve_clr = ~i_ext_valid | w_grant | (r_state == S_EXT);

  arb_sat_counter #(
    .W     (SW),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve_cnt),
    .o_sat (w_starve_sat)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_CPU;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_beat_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_grant     = 1'b0;
    w_xfer      = 1'b0;
    w_mem_we    = 1'b0;
    o_ext_ready = 1'b0;
    o_cpu_stall = 1'b0;
    o_mem_adtp  = i_cpu_adtp;
    o_mem_a     = i_cpu_addr;
    o_mem_wd    = i_cpu_wdata;
    case (r_state)
      S_CPU: begin
        w_mem_we = i_cpu_req & i_cpu_we;
        if (i_ext_valid && (!i_cpu_req || w_starve_sat)) begin
          w_grant     = 1'b1;
          w_state_nxt = S_EXT;
        end
      end
      S_EXT: begin
        o_ext_ready = 1'b1;
        o_cpu_stall = i_cpu_req;
        o_mem_adtp  = 1'b0;
        o_mem_a     = i_ext_addr;
        o_mem_wd    = i_ext_wdata;
        w_mem_we    = i_ext_valid & i_ext_we;
        w_xfer      = i_ext_valid;
        // Leaving always lands in S_CPU, which serves the CPU for at least one cycle
        if (!i_ext_valid || i_ext_last || (r_beat_cnt == BEAT_LAST)) begin
          w_state_nxt = S_CPU;
          w_beat_nxt  = '0;
        end else begin
          w_beat_nxt  = r_beat_cnt + 1'b1;
        end
      end
    endcase
  end

  assign o_mem_we    = w_mem_we & ~i_rst;
  assign o_cpu_rdata = i_mem_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ext_rvalid <= 1'b0;
      o_ext_rdata  <= '0;
    end else begin
      o_ext_rvalid <= w_xfer & ~i_ext_we;
      if (w_xfer && !i_ext_we) begin
        o_ext_rdata <= i_mem_rd;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed table-driven bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_adtp;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_valid, ext_ready, ext_we, ext_last, ext_rvalid;
  logic [31:0] ext_addr, ext_wdata, ext_rdata;
  logic        mem_we, mem_adtp;
  logic [31:0] mem_a, mem_wd, mem_rd;

  logic [31:0] mem [0:63];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.D_WIDTH(32), .MAX_BURST(8), .STARVE_LIMIT(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_adtp  (cpu_adtp),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_rdata (cpu_rdata),
    .o_cpu_stall (cpu_stall),
    .i_ext_valid (ext_valid),
    .o_ext_ready (ext_ready),
    .i_ext_we    (ext_we),
    .i_ext_addr  (ext_addr),
    .i_ext_wdata (ext_wdata),
    .i_ext_last  (ext_last),
    .o_ext_rvalid(ext_rvalid),
    .o_ext_rdata (ext_rdata),
    .o_mem_we    (mem_we),
    .o_mem_adtp  (mem_adtp),
    .o_mem_a     (mem_a),
    .o_mem_wd    (mem_wd),
    .i_mem_rd    (mem_rd)
  );

  // DataMemory: combinational read, write at the clock edge
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
  assign mem_rd = mem[mem_a[7:2]];

  typedef struct {
    logic        cq, cw, ca;
    logic [31:0] caddr, cwd;
    logic        ev, ew, el;
    logic [31:0] eaddr, ewd;
    logic        x_stall, x_ready, x_we, x_adtp;
    logic [31:0] x_a;
    logic        chk_rd;
    logic [31:0] x_rd;
    logic        x_rvalid;
    logic        chk_erd;
    logic [31:0] x_erd;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t v(
    input logic cq, cw, ca, input logic [31:0] caddr, cwd,
    input logic ev, ew, el, input logic [31:0] eaddr, ewd,
    input logic x_stall, x_ready, x_we, x_adtp, input logic [31:0] x_a,
    input logic chk_rd, input logic [31:0] x_rd, input logic x_rvalid,
    input logic chk_erd, input logic [31:0] x_erd);
    vec_t r;
    r.cq = cq; r.cw = cw; r.ca = ca; r.caddr = caddr; r.cwd = cwd;
    r.ev = ev; r.ew = ew; r.el = el; r.eaddr = eaddr; r.ewd = ewd;
    r.x_stall = x_stall; r.x_ready = x_ready; r.x_we = x_we; r.x_adtp = x_adtp;
    r.x_a = x_a; r.chk_rd = chk_rd; r.x_rd = x_rd; r.x_rvalid = x_rvalid;
    r.chk_erd = chk_erd; r.x_erd = x_erd;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_adtp = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_valid = 0; ext_we = 0; ext_last = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic cpu_read_chk(input string nm, input logic [31:0] a, input logic [31:0] exp);
    idle();
    cpu_req = 1; cpu_addr = a;
    #3;
    chk(nm, cpu_rdata, exp);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [14:0] pat;
  int          nb;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    //      cq cw ca caddr          cwd            ev ew el eaddr          ewd            st rd we ad a              crd rd             rv ce erd
    tbl[0]  = v(1, 1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h10, 0, 32'h0,        0, 1, 32'h0);
    tbl[1]  = v(1, 0, 0, 32'h10, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h10, 1, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[2]  = v(1, 0, 1, 32'h10, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 1, 32'h10, 1, 32'hDEADBEEF, 0, 0, 32'h0);
    tbl[3]  = v(0, 0, 0, 32'h0,  32'h0,        1, 1, 0, 32'h20, 32'h11111111, 0, 0, 0, 0, 32'h0,  0, 32'h0,        0, 0, 32'h0);
    tbl[4]  = v(0, 0, 0, 32'h0,  32'h0,        1, 1, 0, 32'h20, 32'h11111111, 0, 1, 1, 0, 32'h20, 0, 32'h0,        0, 0, 32'h0);
    tbl[5]  = v(0, 0, 0, 32'h0,  32'h0,        1, 1, 0, 32'h24, 32'h22222222, 0, 1, 1, 0, 32'h24, 0, 32'h0,        0, 0, 32'h0);
    tbl[6]  = v(0, 0, 0, 32'h0,  32'h0,        1, 1, 1, 32'h28, 32'h33333333, 0, 1, 1, 0, 32'h28, 0, 32'h0,        0, 0, 32'h0);
    tbl[7]  = v(1, 0, 0, 32'h24, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h24, 1, 32'h22222222, 0, 0, 32'h0);
    tbl[8]  = v(1, 0, 0, 32'h28, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h28, 1, 32'h33333333, 0, 0, 32'h0);
    tbl[9]  = v(1, 0, 0, 32'h20, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h20, 1, 32'h11111111, 0, 0, 32'h0);
    tbl[10] = v(1, 1, 0, 32'h40, 32'h55,       0, 0, 0, 32'h0,  32'h0,        0, 0, 1, 0, 32'h40, 0, 32'h0,        0, 0, 32'h0);
    tbl[11] = v(0, 0, 0, 32'h40, 32'h0,        1, 0, 1, 32'h40, 32'h0,        0, 0, 0, 0, 32'h40, 1, 32'h55,       0, 0, 32'h0);
    tbl[12] = v(0, 0, 0, 32'h40, 32'h0,        1, 0, 1, 32'h40, 32'h0,        0, 1, 0, 0, 32'h40, 1, 32'h55,       0, 0, 32'h0);
    tbl[13] = v(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  0, 32'h0,        1, 1, 32'h55);
    tbl[14] = v(0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h0,  0, 32'h0,        0, 1, 32'h55);
    tbl[15] = v(0, 0, 0, 32'h0,  32'h0,        1, 1, 0, 32'h60, 32'hAA,       0, 0, 0, 0, 32'h0,  0, 32'h0,        0, 0, 32'h0);
    tbl[16] = v(1, 0, 1, 32'h60, 32'h0,        0, 1, 0, 32'h60, 32'hAA,       1, 1, 0, 0, 32'h60, 1, 32'h0,        0, 0, 32'h0);
    tbl[17] = v(1, 0, 0, 32'h60, 32'h0,        0, 0, 0, 32'h0,  32'h0,        0, 0, 0, 0, 32'h60, 1, 32'h0,        0, 0, 32'h0);

    // Reset state, with a CPU store presented that must not reach memory
    rst = 1;
    idle();
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h10; cpu_wdata = 32'h1234;
    #12;
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_stall", {31'b0, cpu_stall}, 32'h0);
    chk("rst_ready", {31'b0, ext_ready}, 32'h0);
    chk("rst_rvalid", {31'b0, ext_rvalid}, 32'h0);
    chk("rst_rdata", ext_rdata, 32'h0);
    tick();
    rst = 0;

    for (int i = 0; i < 18; i++) begin
      cpu_req = tbl[i].cq; cpu_we = tbl[i].cw; cpu_adtp = tbl[i].ca;
      cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      ext_valid = tbl[i].ev; ext_we = tbl[i].ew; ext_last = tbl[i].el;
      ext_addr = tbl[i].eaddr; ext_wdata = tbl[i].ewd;
      #3;
      chk($sformatf("v%0d_stall", i), {31'b0, cpu_stall}, {31'b0, tbl[i].x_stall});
      chk($sformatf("v%0d_ready", i), {31'b0, ext_ready}, {31'b0, tbl[i].x_ready});
      chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, tbl[i].x_we});
      chk($sformatf("v%0d_adtp", i), {31'b0, mem_adtp}, {31'b0, tbl[i].x_adtp});
      chk($sformatf("v%0d_mem_a", i), mem_a, tbl[i].x_a);
      chk($sformatf("v%0d_rvalid", i), {31'b0, ext_rvalid}, {31'b0, tbl[i].x_rvalid});
      if (tbl[i].chk_rd) chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, tbl[i].x_rd);
      if (tbl[i].chk_erd) chk($sformatf("v%0d_ext_rdata", i), ext_rdata, tbl[i].x_erd);
      tick();
    end

    // Starvation: EXT denied 5 cycles, granted on the 6th
    idle();
    tick();
    cpu_req = 1; cpu_addr = 32'h10;
    ext_valid = 1; ext_we = 1; ext_addr = 32'h80; ext_wdata = 32'h77;
    for (int c = 1; c <= 5; c++) begin
      #3;
      chk($sformatf("starve_c%0d_ready", c), {31'b0, ext_ready}, 32'h0);
      chk($sformatf("starve_c%0d_stall", c), {31'b0, cpu_stall}, 32'h0);
      tick();
    end
    ext_last = 1;
    #3;
    chk("starve_c6_ready", {31'b0, ext_ready}, 32'h1);
    chk("starve_c6_stall", {31'b0, cpu_stall}, 32'h1);
    chk("starve_c6_mem_a", mem_a, 32'h80);
    tick();
    ext_last = 0;
    for (int c = 7; c <= 8; c++) begin
      #3;
      chk($sformatf("fair_c%0d_ready", c), {31'b0, ext_ready}, 32'h0);
      chk($sformatf("fair_c%0d_stall", c), {31'b0, cpu_stall}, 32'h0);
      tick();
    end
    idle();
    tick();
    cpu_read_chk("starve_wr_0x80", 32'h80, 32'h77);

    // Burst cap: 12 beats split into 8 + 4 with one CPU cycle between grants
    idle();
    nb = 0;
    pat = '0;
    for (int c = 0; c < 15; c++) begin
      ext_valid = (nb < 12);
      ext_we = 1;
      ext_addr = 32'hC0 + 32'(4 * nb);
      ext_wdata = 32'(nb + 1);
      ext_last = (nb == 11);
      #3;
      pat[c] = ext_ready;
      if (ext_ready && ext_valid) nb++;
      tick();
    end
    chk("cap_ready_pattern", {17'b0, pat}, 32'h3DFE);
    chk("cap_beats", 32'(nb), 32'd12);
    cpu_read_chk("cap_beat8", 32'hDC, 32'd8);
    cpu_read_chk("cap_beat12", 32'hEC, 32'd12);

    // Async reset on beat 2 of a 5-beat burst
    idle();
    tick();
    ext_valid = 1; ext_we = 1; ext_addr = 32'h30; ext_wdata = 32'hB0;
    tick();
    tick();
    ext_we = 0;
    tick();
    ext_we = 1; ext_addr = 32'h38; ext_wdata = 32'hB2;
    #1;
    chk("pre_rst_ready", {31'b0, ext_ready}, 32'h1);
    chk("pre_rst_rvalid", {31'b0, ext_rvalid}, 32'h1);
    chk("pre_rst_rdata", ext_rdata, 32'hB0);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h3C; cpu_wdata = 32'hBAD;
    rst = 1;
    #1;
    chk("mid_rst_ready", {31'b0, ext_ready}, 32'h0);
    chk("mid_rst_rvalid", {31'b0, ext_rvalid}, 32'h0);
    chk("mid_rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("mid_rst_stall", {31'b0, cpu_stall}, 32'h0);
    tick();
    rst = 0;
    cpu_read_chk("rst_keep_0x30", 32'h30, 32'hB0);
    cpu_read_chk("rst_drop_0x38", 32'h38, 32'h0);
    cpu_read_chk("rst_drop_0x3C", 32'h3C, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
